// File: rtl/hex_display_pkg.sv
// Shared types and glyph constants for the hex display driver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hex_display_pkg;

    // One seven-segment digit, active-low, bit0 = segment a .. bit6 = segment g.
    typedef logic [6:0] seg7_t;

    // Update sequencer states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Active-low glyphs for the hex alphabet (lowercase b and d).
    localparam seg7_t HEX_0     = 7'h40;
    localparam seg7_t HEX_1     = 7'h79;
    localparam seg7_t HEX_2     = 7'h24;
    localparam seg7_t HEX_3     = 7'h30;
    localparam seg7_t HEX_4     = 7'h19;
    localparam seg7_t HEX_5     = 7'h12;
    localparam seg7_t HEX_6     = 7'h02;
    localparam seg7_t HEX_7     = 7'h78;
    localparam seg7_t HEX_8     = 7'h00;
    localparam seg7_t HEX_9     = 7'h10;
    localparam seg7_t HEX_A     = 7'h08;
    localparam seg7_t HEX_B     = 7'h03;
    localparam seg7_t HEX_C     = 7'h46;
    localparam seg7_t HEX_D     = 7'h21;
    localparam seg7_t HEX_E     = 7'h06;
    localparam seg7_t HEX_F     = 7'h0E;
    localparam seg7_t HEX_BLANK = 7'h7F;

endpackage

// File: rtl/hex_display_driver_rom.sv
// Combinational nibble-to-glyph decoder, shared by all digits via the index mux.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module hex_glyph_rom
    import hex_display_pkg::*;
(
    input  logic [3:0] i_nibble,
    output seg7_t      o_seg
);

    // Look up the active-low glyph for one hex digit.
    always_comb begin
        o_seg = HEX_BLANK;
        case (i_nibble)
            4'h0: o_seg = HEX_0;
            4'h1: o_seg = HEX_1;
            4'h2: o_seg = HEX_2;
            4'h3: o_seg = HEX_3;
            4'h4: o_seg = HEX_4;
            4'h5: o_seg = HEX_5;
            4'h6: o_seg = HEX_6;
            4'h7: o_seg = HEX_7;
            4'h8: o_seg = HEX_8;
            4'h9: o_seg = HEX_9;
            4'hA: o_seg = HEX_A;
            4'hB: o_seg = HEX_B;
            4'hC: o_seg = HEX_C;
            4'hD: o_seg = HEX_D;
            4'hE: o_seg = HEX_E;
            4'hF: o_seg = HEX_F;
            default: o_seg = HEX_BLANK;
        endcase
    end

endmodule

// File: rtl/hex_display_driver.sv
// Multi-digit hex display driver: decode one digit per clock into shadows, commit all at once.
// Latency: accepted value shows on o_hex_out NUM_DIGITS+1 edges after the accepting edge.
// Backpressure: o_load_ready low while an update is in flight; i_load_valid then ignored. HEX_BLINK_EN builds blink.
module hex_display_driver
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25_000_000
)
(
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_load_valid,
    output logic                      o_load_ready,
    input  logic [4*NUM_DIGITS-1:0]   i_value,
    input  logic                      i_lzb_en,
    input  logic [NUM_DIGITS-1:0]     i_blink_mask,
    output logic                      o_update_done,
    output logic [7*NUM_DIGITS-1:0]   o_hex_out
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VAL_W = 4 * NUM_DIGITS;

    state_t                 r_state;
    state_t                 w_next;
    logic                   w_capture;
    logic                   w_decode;
    logic                   w_commit;

    logic [VAL_W-1:0]       r_value;
    logic                   r_lzb;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_update_done;
    seg7_t                  r_shadow [NUM_DIGITS];
    seg7_t                  r_disp   [NUM_DIGITS];

    logic                   w_last;
    logic [VAL_W-1:0]       w_shifted;
    logic                   w_blank;
    seg7_t                  w_glyph;
    seg7_t                  w_slot;
    logic [NUM_DIGITS-1:0]  w_blank_dig;

    assign w_last = (r_idx == IDX_W'(NUM_DIGITS - 1));

    // Current digit sits in the low nibble; everything from it upward is zero
    // exactly when it is a leading zero. Digit 0 always shows.
    assign w_shifted = r_value >> {r_idx, 2'b00};
    assign w_blank   = r_lzb && (r_idx != '0) && (w_shifted == '0);
    assign w_slot    = w_blank ? HEX_BLANK : w_glyph;

    hex_glyph_rom u_rom (
        .i_nibble (w_shifted[3:0]),
        .o_seg    (w_glyph)
    );

    // Sequencer state register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and per-state strobes.
    always_comb begin
        w_next       = r_state;
        w_capture    = 1'b0;
        w_decode     = 1'b0;
        w_commit     = 1'b0;
        o_load_ready = 1'b0;
        case (r_state)
            IDLE: begin
                o_load_ready = 1'b1;
                if (i_load_valid) begin
                    w_capture = 1'b1;
                    w_next    = DECODE;
                end
            end
            DECODE: begin
                w_decode = 1'b1;
                if (w_last) begin
                    w_next = COMMIT;
                end
            end
            COMMIT: begin
                w_commit = 1'b1;
                w_next   = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Capture, per-digit decode into shadows, and atomic commit to the display.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_value       <= '0;
            r_lzb         <= 1'b0;
            r_idx         <= '0;
            r_update_done <= 1'b0;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                r_shadow[k] <= HEX_BLANK;
                r_disp[k]   <= HEX_BLANK;
            end
        end else begin
            r_update_done <= w_commit;
            if (w_capture) begin
                r_value <= i_value;
                r_lzb   <= i_lzb_en;
                r_idx   <= '0;
            end else if (w_decode) begin
                r_idx <= r_idx + IDX_W'(1);
            end
            if (w_decode) begin
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    if (r_idx == IDX_W'(k)) begin
                        r_shadow[k] <= w_slot;
                    end
                end
            end
            if (w_commit) begin
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    r_disp[k] <= r_shadow[k];
                end
            end
        end
    end

    assign o_update_done = r_update_done;

`ifdef HEX_BLINK_EN
    localparam int CNT_W = $clog2(BLINK_DIV);

    logic [CNT_W-1:0]       r_blink_cnt;
    logic                   r_phase;
    logic [NUM_DIGITS-1:0]  r_mask_cap;
    logic [NUM_DIGITS-1:0]  r_mask_disp;

    // Free-running blink timebase; the mask travels with the value and is
    // committed together with the glyphs so a commit never changes the phase.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
            r_mask_cap  <= '0;
            r_mask_disp <= '0;
        end else begin
            if (r_blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
                r_blink_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + CNT_W'(1);
            end
            if (w_capture) begin
                r_mask_cap <= i_blink_mask;
            end
            if (w_commit) begin
                r_mask_disp <= r_mask_cap;
            end
        end
    end

    assign w_blank_dig = r_phase ? '0 : r_mask_disp;
`else
    logic w_unused_blink;
    assign w_unused_blink = (&i_blink_mask) ^ (BLINK_DIV == 0);
    assign w_blank_dig    = '0;
`endif

    // Drive the pins: committed glyph, or Blank for a blinking digit in its off phase.
    always_comb begin
        o_hex_out = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            o_hex_out[7*k +: 7] = w_blank_dig[k] ? HEX_BLANK : r_disp[k];
        end
    end

endmodule

// File: tb/tb_hex_display_driver.sv
module tb_hex_display_driver;

    localparam int N  = 6;
    localparam int HW = 7 * N;
`ifdef HEX_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif
    localparam logic [HW-1:0] ALL_BLANK = {N{7'h7F}};

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            lv  = 1'b0;
    logic            lzb = 1'b0;
    logic [4*N-1:0]  val = '0;
    logic [N-1:0]    msk = '0;
    logic            ready;
    logic            done;
    logic [HW-1:0]   hex;

    always #5 clk = ~clk;

    hex_display_driver #(.NUM_DIGITS(N), .BLINK_DIV(4)) dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_load_valid  (lv),
        .o_load_ready  (ready),
        .i_value       (val),
        .i_lzb_en      (lzb),
        .i_blink_mask  (msk),
        .o_update_done (done),
        .o_hex_out     (hex)
    );

    typedef struct {
        logic [HW-1:0] hex;
        logic [N-1:0]  mask;
        int            due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   tb_cnt   = 0;
    logic tb_phase = 1'b1;

    // Cycle counter and reference blink timebase (BLINK_DIV = 4).
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            tb_cnt   <= 0;
            tb_phase <= 1'b1;
        end else if (tb_cnt == 3) begin
            tb_cnt   <= 0;
            tb_phase <= ~tb_phase;
        end else begin
            tb_cnt <= tb_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [HW-1:0] shown(input logic [HW-1:0] g, input logic [N-1:0] m);
        logic [HW-1:0] r;
        r = g;
        for (int k = 0; k < N; k++) begin
            if (BLINK_ON && m[k] && !tb_phase) r[7*k +: 7] = 7'h7F;
        end
        return r;
    endfunction

    // Monitor: every update_done pulse must match the oldest pending load.
    always @(negedge clk) begin
        if (!rst && done) begin
            check("done_expected", (sb.size() > 0), 1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check("hex_at_done", hex, shown(mon_e.hex, mon_e.mask));
                check("done_cycle", cyc, mon_e.due);
            end
        end
    end

    // Single load from idle; checks busy window, display hold and one-cycle done pulse.
    task automatic run_load(input logic [4*N-1:0] v, input logic l, input logic [N-1:0] m,
                            input logic [HW-1:0] exp_hex, input logic [HW-1:0] prev);
        exp_t e;
        check("ready_idle", ready, 1);
        check("hex_pre", hex, prev);
        val = v; lzb = l; msk = m; lv = 1'b1;
        e.hex = exp_hex; e.mask = m; e.due = cyc + N + 2;
        sb.push_back(e);
        @(negedge clk);
        lv = 1'b0;
        for (int k = 1; k <= N + 1; k++) begin
            check("ready_busy", ready, 0);
            check("hex_hold", hex, prev);
            @(negedge clk);
        end
        check("ready_back", ready, 1);
        @(negedge clk);
        check("done_one_cycle", done, 0);
    endtask

    localparam logic [HW-1:0] EXP_ABCF = {7'h40, 7'h40, 7'h08, 7'h03, 7'h46, 7'h0E};
    localparam logic [HW-1:0] EXP_ZERO = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
    localparam logic [HW-1:0] EXP_0100 = {7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40};
    localparam logic [HW-1:0] EXP_F00A = {7'h7F, 7'h7F, 7'h0E, 7'h40, 7'h40, 7'h08};
    localparam logic [HW-1:0] EXP_A    = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};
    localparam logic [HW-1:0] EXP_B    = {7'h78, 7'h00, 7'h10, 7'h21, 7'h06, 7'h40};
    localparam logic [HW-1:0] EXP_5    = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h12};

    initial begin
        exp_t e;
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_hex", hex, ALL_BLANK);
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_hex", hex, ALL_BLANK);
        check("idle_done", done, 0);

        // Main decode and leading-zero blanking cases
        run_load(24'h00ABCF, 1'b0, '0, EXP_ABCF, ALL_BLANK);
        run_load(24'h000000, 1'b1, '0, EXP_ZERO, EXP_ABCF);
        run_load(24'h000100, 1'b1, '0, EXP_0100, EXP_ZERO);
        run_load(24'h00F00A, 1'b1, '0, EXP_F00A, EXP_0100);

        // load_valid held during an update: second value waits for ready
        check("ready_idle_hold", ready, 1);
        val = 24'h123456; lzb = 1'b0; msk = '0; lv = 1'b1;
        e.hex = EXP_A; e.mask = '0; e.due = cyc + N + 2;     sb.push_back(e);
        e.hex = EXP_B; e.mask = '0; e.due = cyc + 2 * N + 4; sb.push_back(e);
        @(negedge clk);
        val = 24'h789DE0; lzb = 1'b1;
        for (int k = 1; k <= N + 1; k++) begin
            check("hold_busy_a", ready, 0);
            check("hold_hex_a", hex, EXP_F00A);
            @(negedge clk);
        end
        check("hold_ready_a", ready, 1);
        @(negedge clk);
        lv = 1'b0;
        for (int k = 1; k <= N + 1; k++) begin
            check("hold_busy_b", ready, 0);
            check("hold_hex_b", hex, EXP_A);
            @(negedge clk);
        end
        @(negedge clk);
        check("hold_final", hex, EXP_B);

        // Reset in the middle of an update discards it
        check("ready_idle_rst", ready, 1);
        val = 24'h123456; lzb = 1'b0; lv = 1'b1;
        @(negedge clk);
        lv = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_hex", hex, ALL_BLANK);
        check("midrst_ready", ready, 1);
        check("midrst_done", done, 0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("postrst_hex", hex, ALL_BLANK);

        // Blink on digit 0 (steady when blink is not built)
        run_load(24'h000005, 1'b0, 6'b000001, EXP_5, ALL_BLANK);
        for (int k = 0; k < 16; k++) begin
            check("blink_view", hex, shown(EXP_5, 6'b000001));
            @(negedge clk);
        end

        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
